// File: rtl/timeout_sched_pkg.sv
// timeout_sched_pkg: channel state type, width helpers and default parameters for timeout_sched
package timeout_sched_pkg;
  localparam int NumChDef = 4;
  localparam int DivFactorDef = 16;
  localparam int CntWidthDef = 8;
  typedef enum logic {IDLE, RUN} ch_state_e;
  function automatic int budget_w(int w);
    return w < 1 ? 1 : w;
  endfunction
  function automatic int tick_w(int d);
    return d < 2 ? 1 : $clog2(d);
  endfunction
endpackage

// File: rtl/timeout_sched_tick_gen.sv
// tick_gen: prescaler shared by all channels; en_i/any_run_i gate the count, tick_o strobes every DivFactor running cycles
module tick_gen
  import timeout_sched_pkg::*;
#(
  parameter int DivFactor = DivFactorDef
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic any_run_i,
  output logic tick_o
);
  localparam int CW = tick_w(DivFactor);
  localparam logic [CW-1:0] Last = CW'(DivFactor - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_i)
    if (!rst_ni || !any_run_i) cnt <= '0;
    else if (en_i) cnt <= (cnt == Last) ? '0 : cnt + 1'b1;
  assign tick_o = en_i & any_run_i & (cnt == Last);
endmodule

// File: rtl/timeout_sched.sv
// timeout_sched: NumCh arm/disarm timeout channels sharing one tick_gen; ports arm_valid/ready, arm_budget, disarm, busy, expired, tick
module timeout_sched
  import timeout_sched_pkg::*;
#(
  parameter int NumCh = NumChDef,
  parameter int DivFactor = DivFactorDef,
  parameter int CntWidth = CntWidthDef
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [NumCh-1:0]          arm_valid_i,
  output logic [NumCh-1:0]          arm_ready_o,
  input  logic [NumCh*CntWidth-1:0] arm_budget_i,
  input  logic [NumCh-1:0]          disarm_i,
  output logic [NumCh-1:0]          busy_o,
  output logic [NumCh-1:0]          expired_o,
  output logic                      tick_o
);
  typedef logic [budget_w(CntWidth)-1:0] budget_t;
  tick_gen #(.DivFactor(DivFactor)) u_tick (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .en_i(en_i),
    .any_run_i(|busy_o),
    .tick_o(tick_o)
  );
  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    ch_state_e state, state_n;
    budget_t rem, rem_n;
    logic exp_q, exp_n;
    always_ff @(posedge clk_i)
      if (!rst_ni) begin
        state <= IDLE;
        rem <= '0;
        exp_q <= 1'b0;
      end else begin
        state <= state_n;
        rem <= rem_n;
        exp_q <= exp_n;
      end
    always_comb begin
      state_n = state;
      rem_n = rem;
      exp_n = 1'b0;
      if (state == IDLE) begin
        if (arm_valid_i[i]) begin
          state_n = RUN;
          rem_n = arm_budget_i[i*CntWidth +: CntWidth];
        end
      end else if (disarm_i[i]) state_n = IDLE;
      else if (tick_o) begin
        if (rem == '0) begin
          state_n = IDLE;
          exp_n = 1'b1;
        end else rem_n = rem - 1'b1;
      end
    end
    assign arm_ready_o[i] = state == IDLE;
    assign busy_o[i] = state == RUN;
    assign expired_o[i] = exp_q;
  end
endmodule

// File: tb/tb_timeout_sched.sv
// tb_timeout_sched: directed checks of timeout_sched with DivFactor=4 and DivFactor=1 instances
module tb_timeout_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic en, enb;
  logic [1:0] av, ar, dis, busy, expd, avb, arb, disb, busyb, expb;
  logic [15:0] bud, budb;
  logic tk, tkb;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  timeout_sched #(.NumCh(2), .DivFactor(4), .CntWidth(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .arm_valid_i(av), .arm_ready_o(ar),
    .arm_budget_i(bud), .disarm_i(dis), .busy_o(busy), .expired_o(expd), .tick_o(tk)
  );
  timeout_sched #(.NumCh(2), .DivFactor(1), .CntWidth(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(enb), .arm_valid_i(avb), .arm_ready_o(arb),
    .arm_budget_i(budb), .disarm_i(disb), .busy_o(busyb), .expired_o(expb), .tick_o(tkb)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b1; enb = 1'b1;
    av = '0; dis = '0; bud = '0; avb = '0; disb = '0; budb = '0;
    cyc(); cyc(); #1;
    chk("rst_busy", busy, 0); chk("rst_exp", expd, 0); chk("rst_tick", tk, 0);
    chk("rst_ready", ar, 2'b11); chk("rst_ready_b", arb, 2'b11); chk("rst_tick_b", tkb, 0);
    cyc(); rst_n = 1'b1; #1;
    chk("post_rst_ready", ar, 2'b11);
    cyc(); av = 2'b01; bud = 16'h0002; #1;
    chk("s1_ready", ar[0], 1);
    for (int c = 1; c <= 14; c++) begin
      cyc(); av = '0; #1;
      chk("s1_tick", tk, c == 4 || c == 8 || c == 12);
      chk("s1_exp", expd, (c == 13) ? 2'b01 : 2'b00);
      chk("s1_busy", busy[0], c >= 1 && c <= 12);
    end
    cyc(); av = 2'b01; bud = 16'h0000; #1;
    for (int c = 1; c <= 6; c++) begin
      cyc(); av = (c == 2) ? 2'b10 : 2'b00; #1;
      chk("s2_tick", tk, c == 4);
      chk("s2_exp", expd, (c == 5) ? 2'b11 : 2'b00);
      chk("s2_busy0", busy[0], c >= 1 && c <= 4);
      chk("s2_busy1", busy[1], c >= 3 && c <= 4);
    end
    cyc(); av = 2'b01; bud = 16'h0003; #1;
    for (int c = 1; c <= 20; c++) begin
      cyc(); av = '0; dis = (c == 16) ? 2'b01 : 2'b00; #1;
      chk("s3_exp", expd, 0);
      if (c == 16) chk("s3_tick4", tk, 1);
      if (c == 17) begin
        chk("s3_busy", busy[0], 0);
        chk("s3_ready", ar[0], 1);
      end
    end
    cyc(); av = 2'b01; bud = 16'h0001; #1;
    for (int c = 1; c <= 15; c++) begin
      cyc(); av = '0; en = !(c >= 5 && c <= 9); #1;
      chk("s4_tick", tk, c == 4 || c == 13);
      chk("s4_exp", expd, (c == 14) ? 2'b01 : 2'b00);
    end
    cyc(); av = 2'b01; bud = 16'h0000; #1;
    for (int c = 1; c <= 15; c++) begin
      cyc(); bud = 16'h0001; av = (c <= 5) ? 2'b01 : 2'b00; #1;
      chk("s5_ready", ar[0], !((c >= 1 && c <= 4) || (c >= 6 && c <= 13)));
      chk("s5_exp", expd, (c == 5 || c == 14) ? 2'b01 : 2'b00);
      chk("s5_tick", tk, c == 4 || c == 9 || c == 13);
    end
    cyc(); av = 2'b01; bud = 16'h0002; #1;
    for (int c = 1; c <= 14; c++) begin
      cyc(); av = '0; rst_n = (c != 12); #1;
      if (c == 12) chk("s6_tick_pre", tk, 1);
      if (c >= 13) begin
        chk("s6_exp", expd, 0); chk("s6_busy", busy, 0);
        chk("s6_tick", tk, 0); chk("s6_ready", ar, 2'b11);
      end
    end
    cyc(); avb = 2'b01; budb = 16'h0002; #1;
    for (int c = 1; c <= 5; c++) begin
      cyc(); avb = '0; #1;
      chk("s6b_exp", expb, (c == 4) ? 2'b01 : 2'b00);
      chk("s6b_tick", tkb, c >= 1 && c <= 3);
      chk("s6b_busy", busyb[0], c >= 1 && c <= 3);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
